gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//   Parametrised up/down counter that keeps a binary count and its registered
//   Gray-code image in lock-step. It also includes a registered Gray-to-binary
//   decoder for incoming Gray values, such as a pointer from another domain.
//   It is the sequential successor of the combinational b2g converter and is
//   used for FIFO pointers and position counters.
// PARAMETERS
//   WIDTH  4  count / code width in bits (>=2); count range 0 .. 2**WIDTH-1
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   rst       in   1      synchronous, active-high reset
//   en        in   1      count enable; one step per cycle while high
//   up_dn     in   1      1 = count up, 0 = count down (sampled with en)
//   load      in   1      load request; priority over en
//   load_bin  in   WIDTH  binary value loaded when load=1
//   bin_out   out  WIDTH  registered binary count
//   gray_out  out  WIDTH  registered Gray code of bin_out (same cycle)
//   tc        out  1      one-cycle pulse: outputs currently show a wrapped value
//   gin       in   WIDTH  external Gray value to decode
//   gin_vld   in   1      gin qualifier
//   gdec_bin  out  WIDTH  registered binary decode of gin
//   gdec_vld  out  1      gdec_bin qualifier
// BEHAVIOUR
//   - Reset (rst=1 at edge): bin_out=0, gray_out=0, tc=0, gdec_bin=0, gdec_vld=0.
//     rst overrides load/en/gin_vld. Mid-count reset returns to 0 on that edge.
//   - Next-state priority: rst > load > en > hold.
//   - load=1: bin_out<=load_bin and gray_out<=load_bin^(load_bin>>1) on the
//     next edge, regardless of en. tc<=0.
//   - en=1, load=0: bin_out<=bin_out+1 (up_dn=1) or bin_out-1 (up_dn=0).
//     Arithmetic is modulo 2**WIDTH. gray_out<=nxt^(nxt>>1), where nxt is
//     the new binary value. gray_out is never derived from the old bin_out.
//   - en=0, load=0: bin_out and gray_out hold. tc<=0.
//   - Latency: 1 cycle from en/load to both outputs. bin_out and gray_out
//     always satisfy gray_out == bin_out^(bin_out>>1).
//   - Successive gray_out values under en differ in exactly one bit,
//     including across the wrap.
//   - tc<=1 only on a wrapping step: up from all-ones to 0, or down from 0
//     to all-ones. Otherwise tc<=0. A load of any value never asserts tc.
//   - up_dn may change every cycle; each step uses its value at that edge.
//   - Decoder path: if gin_vld=1, gdec_bin[WIDTH-1]<=gin[WIDTH-1] and
//     gdec_bin[i]<=gdec_bin_nxt[i+1]^gin[i] (prefix XOR from MSB).
//     The decode is combinational within the cycle and registered once.
//     gdec_vld<=gin_vld every cycle. gdec_bin holds when gin_vld=0.
//     Latency is 1 cycle. The decoder is independent of the counter.
// TESTING (WIDTH=4 unless stated)
//   - Reset: hold rst 2 cycles with en=1, load=1 -> bin_out=0, gray_out=0,
//     tc=0, gdec_vld=0.
//   - Up sweep: en=1, up_dn=1 for 17 cycles from 0 -> gray sequence
//     0000,0001,0011,0010,...,1000,0000; Hamming distance 1 each step;
//     tc=1 only on the cycle bin_out wraps 15->0.
//   - Down wrap: from 0, en=1, up_dn=0 -> bin_out=1111, gray_out=1000, tc=1;
//     the next step gives 1110/1001 with tc=0.
//   - Load: load_bin=1011 with load=1, en=1 -> next cycle bin_out=1011,
//     gray_out=1110, tc=0. Then en=0 for 3 cycles -> outputs hold.
//   - Reset mid-count at bin_out=0111 (gray 0100) -> 0/0 on the next edge.
//     Counting resumes from 0 after rst drops.
//   - Decoder: gin=1110 with gin_vld=1 -> next cycle gdec_bin=1011,
//     gdec_vld=1. Then gin_vld=0 -> gdec_vld=0 and gdec_bin holds at 1011.
//     Check the round trip over all 16 codes and WIDTH=8 random vectors.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a lock-step registered Gray image, plus an
// independent registered Gray-to-binary decoder for externally supplied codes.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  input  logic [WIDTH-1:0] gin,
  input  logic             gin_vld,
  output logic [WIDTH-1:0] gdec_bin,
  output logic             gdec_vld
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] gdec_bin_q, gdec_bin_d;
  logic [WIDTH-1:0] gdec_bin_nxt;
  logic             gdec_vld_q, gdec_vld_d;

  // Gray image is encoded from the new binary value so both registers agree.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_d = bin_q + ONE;
        tc_d  = &bin_q;
      end else begin
        bin_d = bin_q - ONE;
        tc_d  = ~|bin_q;
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Prefix XOR running from the MSB down.
  always_comb begin
    gdec_bin_nxt[WIDTH-1] = gin[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      gdec_bin_nxt[i] = gdec_bin_nxt[i+1] ^ gin[i];
    end
    gdec_bin_d = gin_vld ? gdec_bin_nxt : gdec_bin_q;
    gdec_vld_d = gin_vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      gray_q     <= '0;
      tc_q       <= 1'b0;
      gdec_bin_q <= '0;
      gdec_vld_q <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      gray_q     <= gray_d;
      tc_q       <= tc_d;
      gdec_bin_q <= gdec_bin_d;
      gdec_vld_q <= gdec_vld_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tc       = tc_q;
  assign gdec_bin = gdec_bin_q;
  assign gdec_vld = gdec_vld_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: 4-bit counter/decoder behaviour plus an
// 8-bit instance exercised with random load and decode vectors.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, gin_vld;
  logic [3:0] load_bin, gin;
  logic [3:0] bin_out, gray_out, gdec_bin;
  logic       tc, gdec_vld;

  logic       en8, up_dn8, load8, gin_vld8;
  logic [7:0] load_bin8, gin8;
  logic [7:0] bin_out8, gray_out8, gdec_bin8;
  logic       tc8, gdec_vld8;

  int checks = 0;
  int errors = 0;

  logic [3:0] gray4 [16];
  logic [3:0] prev_gray;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .bin_out(bin_out), .gray_out(gray_out), .tc(tc),
    .gin(gin), .gin_vld(gin_vld), .gdec_bin(gdec_bin), .gdec_vld(gdec_vld)
  );

  gray_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .up_dn(up_dn8), .load(load8),
    .load_bin(load_bin8), .bin_out(bin_out8), .gray_out(gray_out8), .tc(tc8),
    .gin(gin8), .gin_vld(gin_vld8), .gdec_bin(gdec_bin8), .gdec_vld(gdec_vld8)
  );

  // Drive the 4-bit inputs, then let one rising edge pass and settle.
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [3:0] lb,
                               input logic gv, input logic [3:0] g);
    rst = r; en = e; up_dn = u; load = l; load_bin = lb;
    gin_vld = gv; gin = g;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_bin,
                             input logic [3:0] exp_gray, input logic exp_tc);
    checks++;
    assert (bin_out === exp_bin) else begin
      errors++;
      $error("[TB] FAIL %s bin_out got %b want %b", tag, bin_out, exp_bin);
    end
    checks++;
    assert (gray_out === exp_gray) else begin
      errors++;
      $error("[TB] FAIL %s gray_out got %b want %b", tag, gray_out, exp_gray);
    end
    checks++;
    assert (tc === exp_tc) else begin
      errors++;
      $error("[TB] FAIL %s tc got %b want %b", tag, tc, exp_tc);
    end
  endtask

  task automatic checkDecode(input string tag, input logic [3:0] exp_bin,
                             input logic exp_vld);
    checks++;
    assert (gdec_bin === exp_bin) else begin
      errors++;
      $error("[TB] FAIL %s gdec_bin got %b want %b", tag, gdec_bin, exp_bin);
    end
    checks++;
    assert (gdec_vld === exp_vld) else begin
      errors++;
      $error("[TB] FAIL %s gdec_vld got %b want %b", tag, gdec_vld, exp_vld);
    end
  endtask

  initial begin
    gray4 = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    en8 = 1'b0; up_dn8 = 1'b0; load8 = 1'b0; load_bin8 = '0;
    gin8 = '0; gin_vld8 = 1'b0;

    // Reset held two cycles with everything else requesting action.
    applyStimulus(1, 1, 1, 1, 4'h5, 1, 4'h3);
    applyStimulus(1, 1, 1, 1, 4'h5, 1, 4'h3);
    checkOutput("reset", 4'h0, 4'h0, 1'b0);
    checkDecode("reset_dec", 4'h0, 1'b0);

    // Up sweep of 17 steps: wraps once at step 16.
    prev_gray = gray_out;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(0, 1, 1, 0, 4'h0, 0, 4'h0);
      checkOutput($sformatf("up_%0d", i), 4'(i % 16), gray4[i % 16], i == 16);
      checks++;
      assert ($countones(gray_out ^ prev_gray) === 1) else begin
        errors++;
        $error("[TB] FAIL hamming_%0d got %0d want 1", i,
               $countones(gray_out ^ prev_gray));
      end
      prev_gray = gray_out;
    end

    // Down through zero.
    applyStimulus(0, 1, 0, 0, 4'h0, 0, 4'h0);
    checkOutput("down_to0", 4'h0, 4'h0, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'h0, 0, 4'h0);
    checkOutput("down_wrap", 4'hF, 4'h8, 1'b1);
    applyStimulus(0, 1, 0, 0, 4'h0, 0, 4'h0);
    checkOutput("down_after", 4'hE, 4'h9, 1'b0);

    // Load beats enable, then hold.
    applyStimulus(0, 1, 1, 1, 4'hB, 0, 4'h0);
    checkOutput("load_b", 4'hB, 4'hE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 4'h0, 0, 4'h0);
      checkOutput($sformatf("hold_%0d", i), 4'hB, 4'hE, 1'b0);
    end

    // Loading while sitting at all-ones with en/up must not flag a wrap.
    applyStimulus(0, 0, 1, 1, 4'hF, 0, 4'h0);
    checkOutput("load_f", 4'hF, 4'h8, 1'b0);
    applyStimulus(0, 1, 1, 1, 4'h0, 0, 4'h0);
    checkOutput("load_0_no_tc", 4'h0, 4'h0, 1'b0);

    // Mid-count reset.
    applyStimulus(0, 0, 1, 1, 4'h6, 0, 4'h0);
    applyStimulus(0, 1, 1, 0, 4'h0, 0, 4'h0);
    checkOutput("pre_rst", 4'h7, 4'h4, 1'b0);
    applyStimulus(1, 1, 1, 0, 4'h0, 0, 4'h0);
    checkOutput("mid_rst", 4'h0, 4'h0, 1'b0);
    applyStimulus(0, 1, 1, 0, 4'h0, 0, 4'h0);
    checkOutput("resume", 4'h1, 4'h1, 1'b0);

    // Direction changing every cycle, including both wrap directions.
    applyStimulus(0, 1, 1, 0, 4'h0, 0, 4'h0);
    checkOutput("alt_up", 4'h2, 4'h3, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'h0, 0, 4'h0);
    checkOutput("alt_dn1", 4'h1, 4'h1, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'h0, 0, 4'h0);
    checkOutput("alt_dn0", 4'h0, 4'h0, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'h0, 0, 4'h0);
    checkOutput("alt_dnwrap", 4'hF, 4'h8, 1'b1);
    applyStimulus(0, 1, 1, 0, 4'h0, 0, 4'h0);
    checkOutput("alt_upwrap", 4'h0, 4'h0, 1'b1);

    // Decoder path.
    applyStimulus(0, 0, 1, 0, 4'h0, 1, 4'hE);
    checkDecode("dec_e", 4'hB, 1'b1);
    applyStimulus(0, 0, 1, 0, 4'h0, 0, 4'h5);
    checkDecode("dec_hold", 4'hB, 1'b0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 0, 1, 0, 4'h0, 1, gray4[k]);
      checkDecode($sformatf("round_%0d", k), 4'(k), 1'b1);
    end

    // 8-bit instance: random loads and decodes of the matching Gray code.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      load8 = 1'b1; load_bin8 = b;
      gin_vld8 = 1'b1; gin8 = b ^ (b >> 1);
      applyStimulus(0, 0, 1, 0, 4'h0, 0, 4'h0);
      checks++;
      assert (gray_out8 === (b ^ (b >> 1))) else begin
        errors++;
        $error("[TB] FAIL w8_gray_%0d got %h want %h", n, gray_out8, b ^ (b >> 1));
      end
      checks++;
      assert (gdec_bin8 === b && gdec_vld8 === 1'b1) else begin
        errors++;
        $error("[TB] FAIL w8_dec_%0d got %h/%b want %h/1", n, gdec_bin8, gdec_vld8, b);
      end
    end
    load8 = 1'b0; gin_vld8 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
